data_bus_arbiter: RTL and testbench

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/config_pkg.sv | 4 +
 rtl/data_bus_pkg.sv | 8 +
 rtl/rr_pick.sv | 30 +++
 rtl/data_bus_arbiter.sv | 116 +++++++++++
 tb/tb_data_bus_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// System-level configuration shared by the bus fabric.
package config_pkg;
  localparam int NMST = 3;
endpackage

// File: rtl/data_bus_pkg.sv
// Data bus widths and the arbiter state encoding.
package data_bus_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, HOLD, ACCESS} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational priority picker: first requester found scanning from prio upward, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] prio,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  // Scan from farthest to nearest so the nearest requester to prio is the last (winning) write.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(prio) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j[IW-1:0];
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// N-to-1 data bus arbiter, one outstanding transaction at a time.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter  int NMST  = config_pkg::NMST,
  parameter  int RR_EN = 1,
  localparam int IW    = (NMST > 1) ? $clog2(NMST) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NMST-1:0]           mst_req,
  input  logic [NMST-1:0][AW-1:0]   mst_addr,
  input  logic [NMST-1:0]           mst_we,
  input  logic [NMST-1:0][BW-1:0]   mst_be,
  input  logic [NMST-1:0][DW-1:0]   mst_wdata,
  output logic [NMST-1:0]           mst_gnt,
  output logic [NMST-1:0]           mst_rvalid,
  output logic [NMST-1:0]           mst_err,
  output logic [NMST-1:0][DW-1:0]   mst_rdata,
  output logic                      out_req,
  output logic [AW-1:0]             out_addr,
  output logic                      out_we,
  output logic [BW-1:0]             out_be,
  output logic [DW-1:0]             out_wdata,
  input  logic                      out_gnt,
  input  logic                      out_rvalid,
  input  logic                      out_err,
  input  logic [DW-1:0]             out_rdata,
  output logic [IW-1:0]             owner_o,
  output logic                      busy_o
);
  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, prio_q, prio_eff;
  logic [IW-1:0]   pick_idx, sel;
  logic [NMST-1:0] pick_gnt;
  logic            pick_any, sel_vld;

  // Fixed priority is round-robin pinned to index 0.
  assign prio_eff = (RR_EN != 0) ? prio_q : '0;

  rr_pick #(.N(NMST), .IW(IW)) u_pick (
    .req  (mst_req),
    .prio (prio_eff),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Owner latched at arbitration; priority pointer advances past the owner on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      if (state_q == IDLE && pick_any) owner_q <= pick_idx;
      if (RR_EN != 0 && state_q == ACCESS && out_rvalid)
        prio_q <= (owner_q == IW'(NMST - 1)) ? '0 : owner_q + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = out_gnt ? ACCESS : HOLD;
      HOLD:    if (!mst_req[owner_q]) state_d = IDLE;
               else if (out_gnt)      state_d = ACCESS;
      ACCESS:  if (out_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request forwarding, grant and response routing.
  always_comb begin
    sel        = '0;
    sel_vld    = 1'b0;
    mst_gnt    = '0;
    mst_rvalid = '0;
    mst_err    = '0;
    mst_rdata  = '0;
    case (state_q)
      IDLE: begin
        sel     = pick_idx;
        sel_vld = pick_any;
        if (out_gnt && rst) mst_gnt = pick_gnt;
      end
      HOLD: begin
        // Locked to owner so the forwarded request cannot change before grant.
        sel     = owner_q;
        sel_vld = mst_req[owner_q];
        if (out_gnt && sel_vld) mst_gnt[owner_q] = 1'b1;
      end
      ACCESS: begin
        mst_rvalid[owner_q] = out_rvalid;
        mst_err[owner_q]    = out_err;
        mst_rdata[owner_q]  = out_rdata;
      end
      default: ;
    endcase
    if (!rst) sel_vld = 1'b0;
    out_req   = sel_vld;
    out_addr  = sel_vld ? mst_addr[sel]  : '0;
    out_we    = sel_vld ? mst_we[sel]    : 1'b0;
    out_be    = sel_vld ? mst_be[sel]    : '0;
    out_wdata = sel_vld ? mst_wdata[sel] : '0;
    owner_o   = (state_q == IDLE) ? (sel_vld ? sel : '0) : owner_q;
  end

  assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with three masters.
module tb_data_bus_arbiter;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2:0]        mst_req;
  logic [2:0][31:0]  mst_addr;
  logic [2:0]        mst_we;
  logic [2:0][3:0]   mst_be;
  logic [2:0][31:0]  mst_wdata;
  logic [2:0]        mst_gnt, mst_rvalid, mst_err;
  logic [2:0][31:0]  mst_rdata;
  logic              out_req, out_we;
  logic [31:0]       out_addr, out_wdata;
  logic [3:0]        out_be;
  logic              out_gnt, out_rvalid, out_err;
  logic [31:0]       out_rdata;
  logic [1:0]        owner_o;
  logic              busy_o;

  // fixed-priority instance
  logic [2:0]        fp_req, fp_mst_gnt, fp_mst_rvalid, fp_mst_err;
  logic [2:0][31:0]  fp_mst_rdata;
  logic              fp_out_req, fp_out_we, fp_out_gnt, fp_out_rvalid;
  logic [31:0]       fp_out_addr, fp_out_wdata;
  logic [3:0]        fp_out_be;
  logic [1:0]        fp_owner_o;
  logic              fp_busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.NMST(3), .RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .mst_req(mst_req), .mst_addr(mst_addr), .mst_we(mst_we), .mst_be(mst_be),
    .mst_wdata(mst_wdata), .mst_gnt(mst_gnt), .mst_rvalid(mst_rvalid),
    .mst_err(mst_err), .mst_rdata(mst_rdata),
    .out_req(out_req), .out_addr(out_addr), .out_we(out_we), .out_be(out_be),
    .out_wdata(out_wdata), .out_gnt(out_gnt), .out_rvalid(out_rvalid),
    .out_err(out_err), .out_rdata(out_rdata),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  data_bus_arbiter #(.NMST(3), .RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .mst_req(fp_req), .mst_addr(mst_addr), .mst_we(mst_we), .mst_be(mst_be),
    .mst_wdata(mst_wdata), .mst_gnt(fp_mst_gnt), .mst_rvalid(fp_mst_rvalid),
    .mst_err(fp_mst_err), .mst_rdata(fp_mst_rdata),
    .out_req(fp_out_req), .out_addr(fp_out_addr), .out_we(fp_out_we), .out_be(fp_out_be),
    .out_wdata(fp_out_wdata), .out_gnt(fp_out_gnt), .out_rvalid(fp_out_rvalid),
    .out_err(1'b0), .out_rdata(32'h0),
    .owner_o(fp_owner_o), .busy_o(fp_busy_o)
  );

  task automatic clear_inputs();
    mst_req = '0; mst_we = '0; mst_be = '0; mst_wdata = '0;
    mst_addr[0] = 32'h0000_0100; mst_addr[1] = 32'h0000_0200; mst_addr[2] = 32'h0000_0300;
    out_gnt = 1'b0; out_rvalid = 1'b0; out_err = 1'b0; out_rdata = '0;
    fp_req = '0; fp_out_gnt = 1'b0; fp_out_rvalid = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released: the start of cycle 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    mst_req = 3'b111; out_gnt = 1'b1; out_rvalid = 1'b1; out_err = 1'b1;
    #1;
    checks++; if (out_req !== 1'b0) begin failures++; $display("FAIL reset_out_req got=%b exp=0", out_req); end
    checks++; if (mst_gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", mst_gnt); end
    checks++; if (mst_rvalid !== 3'b000 || mst_err !== 3'b000) begin failures++; $display("FAIL reset_rsp rvalid=%b err=%b exp=000", mst_rvalid, mst_err); end
    checks++; if (busy_o !== 1'b0 || owner_o !== 2'd0) begin failures++; $display("FAIL reset_state busy=%b owner=%0d exp 0/0", busy_o, owner_o); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    do_reset();
    mst_req = 3'b111; out_gnt = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      out_rvalid = (k % 3 == 2);
      #1;
      e = (k % 3 == 0) ? (3'b001 << ((k / 3) % 3)) : 3'b000;
      checks++; if (mst_gnt !== e) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", k, mst_gnt, e); end
      if (k % 3 == 0) begin
        checks++; if (owner_o !== 2'((k / 3) % 3)) begin failures++; $display("FAIL rr_owner cyc=%0d got=%0d exp=%0d", k, owner_o, (k / 3) % 3); end
      end else begin
        checks++; if (out_req !== 1'b0) begin failures++; $display("FAIL rr_access_req cyc=%0d got=%b exp=0", k, out_req); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    mst_addr[1] = 32'h0000_1000; mst_addr[0] = 32'h0000_2000;
    mst_req = 3'b010; out_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) mst_req = 3'b011;
      #1;
      checks++; if (out_req !== 1'b1 || out_addr !== 32'h0000_1000) begin failures++; $display("FAIL hold_addr cyc=%0d req=%b addr=%h exp 1/00001000", k, out_req, out_addr); end
      checks++; if (owner_o !== 2'd1 || mst_gnt !== 3'b000) begin failures++; $display("FAIL hold_owner cyc=%0d owner=%0d gnt=%b exp 1/000", k, owner_o, mst_gnt); end
    end
    @(negedge clk); out_gnt = 1'b1; #1;
    checks++; if (mst_gnt !== 3'b010 || out_addr !== 32'h0000_1000) begin failures++; $display("FAIL hold_grant gnt=%b addr=%h exp 010/00001000", mst_gnt, out_addr); end
    @(negedge clk); mst_req = 3'b001; #1;
    checks++; if (mst_gnt !== 3'b000 || out_req !== 1'b0 || owner_o !== 2'd1) begin failures++; $display("FAIL hold_access gnt=%b req=%b owner=%0d exp 000/0/1", mst_gnt, out_req, owner_o); end
    @(negedge clk); out_rvalid = 1'b1; #1;
    checks++; if (mst_rvalid !== 3'b010) begin failures++; $display("FAIL hold_rvalid got=%b exp=010", mst_rvalid); end
    @(negedge clk); out_rvalid = 1'b0; #1;
    checks++; if (mst_gnt !== 3'b001 || out_addr !== 32'h0000_2000) begin failures++; $display("FAIL hold_next gnt=%b addr=%h exp 001/00002000", mst_gnt, out_addr); end
    clear_inputs();
  endtask

  task automatic test_err_route();
    do_reset();
    mst_req = 3'b100; mst_addr[2] = 32'h0000_3000; out_gnt = 1'b1;
    #1;
    checks++; if (mst_gnt !== 3'b100) begin failures++; $display("FAIL err_gnt got=%b exp=100", mst_gnt); end
    @(negedge clk);
    mst_req = 3'b011; out_rvalid = 1'b1; out_err = 1'b1; out_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (mst_rvalid !== 3'b100 || mst_err !== 3'b100) begin failures++; $display("FAIL err_route rvalid=%b err=%b exp 100/100", mst_rvalid, mst_err); end
    checks++; if (mst_rdata[2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL err_rdata2 got=%h exp=deadbeef", mst_rdata[2]); end
    checks++; if (mst_rdata[0] !== 32'h0 || mst_rdata[1] !== 32'h0) begin failures++; $display("FAIL err_rdata_other m0=%h m1=%h exp 0", mst_rdata[0], mst_rdata[1]); end
    checks++; if (out_req !== 1'b0 || mst_gnt !== 3'b000) begin failures++; $display("FAIL err_access_req req=%b gnt=%b exp 0/000", out_req, mst_gnt); end
    @(negedge clk); mst_req = 3'b000; out_rvalid = 1'b0; out_err = 1'b0; #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL err_idle busy=%b exp=0", busy_o); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mst_req = 3'b001; out_gnt = 1'b1; #1;
    @(negedge clk); mst_req = 3'b000; out_rvalid = 1'b1;
    @(negedge clk); out_rvalid = 1'b0; mst_req = 3'b010; #1;
    checks++; if (mst_gnt !== 3'b010) begin failures++; $display("FAIL rmid_gnt got=%b exp=010", mst_gnt); end
    @(negedge clk); mst_req = 3'b000; rst = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || mst_rvalid !== 3'b000) begin failures++; $display("FAIL rmid_abandon busy=%b rvalid=%b exp 0/000", busy_o, mst_rvalid); end
    @(negedge clk); rst = 1'b1; out_rvalid = 1'b1; #1;
    checks++; if (mst_rvalid !== 3'b000 || busy_o !== 1'b0) begin failures++; $display("FAIL rmid_late_rvalid rvalid=%b busy=%b exp 000/0", mst_rvalid, busy_o); end
    @(negedge clk); out_rvalid = 1'b0; mst_req = 3'b011; #1;
    checks++; if (mst_gnt !== 3'b001) begin failures++; $display("FAIL rmid_prio gnt=%b exp=001", mst_gnt); end
    clear_inputs();
  endtask

  task automatic test_drop_hold();
    do_reset();
    mst_req = 3'b010; out_gnt = 1'b0; #1;
    checks++; if (out_req !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL drop_start req=%b busy=%b exp 1/0", out_req, busy_o); end
    @(negedge clk); mst_req = 3'b000; out_gnt = 1'b1; #1;
    checks++; if (busy_o !== 1'b1 || out_req !== 1'b0 || mst_gnt !== 3'b000) begin failures++; $display("FAIL drop_hold busy=%b req=%b gnt=%b exp 1/0/000", busy_o, out_req, mst_gnt); end
    checks++; if (out_addr !== 32'h0) begin failures++; $display("FAIL drop_addr got=%h exp=0", out_addr); end
    @(negedge clk); out_gnt = 1'b0; #1;
    checks++; if (busy_o !== 1'b0 || out_req !== 1'b0) begin failures++; $display("FAIL drop_idle busy=%b req=%b exp 0/0", busy_o, out_req); end
    clear_inputs();
  endtask

  task automatic test_fixed();
    logic [2:0] e;
    do_reset();
    fp_req = 3'b101; fp_out_gnt = 1'b1; fp_out_rvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      e = (k % 2 == 0) ? 3'b001 : 3'b000;
      checks++; if (fp_mst_gnt !== e) begin failures++; $display("FAIL fixed_gnt cyc=%0d got=%b exp=%b", k, fp_mst_gnt, e); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_hold();
    test_err_route();
    test_reset_mid();
    test_drop_hold();
    test_fixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
